// File: rtl/cdown_timer.sv
// cdown_timer: loadable BCD MM:SS.cc countdown timer with start/stop FSM and one-shot expiry.
// Optional CDOWN_TIMER_AUTO_RELOAD_EN: on expiry, reload the last loaded value and keep running.
`default_nettype none

module cdown_timer #(
  parameter int TICK_DIV    = 100000,
  parameter int CounterBits = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [23:0] load_val,
  input  logic        start,
  input  logic        stop,
  output logic [23:0] time_q,
  output logic        running,
  output logic        expired,
  output logic        done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CounterBits-1:0] TICK_LAST = CounterBits'(TICK_DIV - 1);

  logic [1:0]             state_q, state_d;
  logic [CounterBits-1:0] presc_q, presc_d;
  logic [23:0]            time_d;
  logic                   done_q, done_d;
  logic                   tick;
  logic [23:0]            dec_val;
  logic [23:0]            load_clean;
`ifdef CDOWN_TIMER_AUTO_RELOAD_EN
  logic [23:0]            reload_q, reload_d;
`endif

  function automatic logic [3:0] digit_max(input int idx);
    return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [23:0] sanitise(input logic [23:0] v);
    logic [23:0] r;
    logic [3:0]  d;
    r = v;
    for (int i = 0; i < 6; i++) begin
      d = v[i*4 +: 4];
      if (d > digit_max(i)) d = digit_max(i);
      r[i*4 +: 4] = d;
    end
    return r;
  endfunction

  // Ripple borrow from c_lo upward; a zero digit with borrow-in reloads its max.
  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    logic [23:0] r;
    logic [3:0]  d;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = v[i*4 +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          d = digit_max(i);
        end else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      r[i*4 +: 4] = d;
    end
    return r;
  endfunction

  assign tick       = (state_q == ST_RUN) && (presc_q == TICK_LAST);
  assign dec_val    = bcd_dec(time_q);
  assign load_clean = sanitise(load_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      time_q   <= '0;
      done_q   <= 1'b0;
`ifdef CDOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      time_q   <= time_d;
      done_q   <= done_d;
`ifdef CDOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    time_d   = time_q;
    done_d   = 1'b0;
`ifdef CDOWN_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      time_d  = load_clean;
      presc_d = '0;
      state_d = ST_IDLE;
`ifdef CDOWN_TIMER_AUTO_RELOAD_EN
      reload_d = load_clean;
`endif
    end else if (stop) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (time_q != 24'd0)) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        ST_PAUSE: begin
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tick) begin
            presc_d = '0;
            time_d  = dec_val;
            if (dec_val == 24'd0) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
`ifdef CDOWN_TIMER_AUTO_RELOAD_EN
              if (reload_q != 24'd0) begin
                time_d  = reload_q;
                state_d = ST_RUN;
              end
`endif
            end
          end else begin
            presc_d = presc_q + CounterBits'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    running = (state_q == ST_RUN);
    expired = (state_q == ST_DONE);
    done    = done_q;
  end

endmodule

`default_nettype wire

// File: doc/cdown_timer.md
Name: cdown_timer

Overview:
- Loadable BCD countdown timer: MM:SS.cc, range 00:00.00 to 59:59.99.
- Complement to the stop-watch's cascaded up-counting dividers: a down-counting digit chain with borrow-in/borrow-out instead of carry.
- Includes a start/stop control FSM and a one-shot expiry event.
- Sits beside the stop-watch datapath; time_q feeds the same 7-segment display mux.

Parameters:
- TICK_DIV, 100000: clk cycles per 0.01 s tick (prescaler modulus, >=2).
- CounterBits, 17: prescaler width; must satisfy 2^CounterBits >= TICK_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle pulse; capture load_val.
- load_val  in  24  BCD {m_hi,m_lo,s_hi,s_lo,c_hi,c_lo}, 4 bits each.
- start  in  1  one-cycle pulse; begin or resume counting.
- stop  in  1  one-cycle pulse; pause counting.
- time_q  out  24  current BCD value, same packing as load_val.
- running  out  1  high while in RUN.
- expired  out  1  high while in DONE.
- done  out  1  one-cycle pulse on reaching zero.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is asynchronous and active-low (rst_n).
  - Reset values: time_q=0, prescaler=0, state=IDLE, running=0, expired=0, done=0.
- FSM states: IDLE, RUN, PAUSE, DONE.
- Priority each cycle: load > stop > start.
- load, any state:
  - time_q <= sanitised load_val; prescaler <= 0; state <= IDLE; done=0.
  - Visible on time_q the next cycle.
- Sanitising: digit limits are c_lo/c_hi/s_lo/m_lo max 9, s_hi/m_hi max 5. Any digit above its limit saturates to the limit (e.g. load_val 0x7A_0000 -> 0x59_0000).
- start:
  - IDLE with time_q!=0 -> RUN, prescaler cleared.
  - PAUSE -> RUN, prescaler retained.
  - Ignored in IDLE with time_q==0, in RUN, and in DONE.
- stop: RUN -> PAUSE, prescaler and time_q held. Ignored in other states.
- start and stop in the same cycle: stop wins.
- Prescaler:
  - Counts only in RUN, 0..TICK_DIV-1.
  - tick asserted when prescaler==TICK_DIV-1 in RUN; prescaler then wraps to 0.
  - First decrement occurs TICK_DIV cycles after start is sampled from IDLE.
- Decrement on tick, ripple borrow from c_lo upward:
  - Digit with borrow-in and value 0 -> reloads its max and asserts borrow-out.
  - Otherwise digit - 1, no borrow-out.
  - c_lo always has borrow-in on tick.
  - Examples: 01:00.00 -> 00:59.99; 10:00.00 -> 09:59.99.
- Expiry:
  - When a tick makes time_q 000000: done=1 for that one cycle (registered, aligned with time_q becoming 0); state -> DONE.
  - The chain never wraps below zero.
- DONE: time_q holds 0, expired=1; only load leaves DONE (to IDLE, expired cleared).
- running = (state==RUN); expired = (state==DONE). Both registered with the state.
- load coinciding with the expiring tick: load wins, no done pulse.
- Reset mid-count: immediate return to reset values regardless of clk.

Optional Feature:
- Macro: CDOWN_TIMER_AUTO_RELOAD_EN.
- Defined:
  - A 24-bit reload register captures every sanitised load.
  - On expiry, done pulses, time_q <= reload register, state stays RUN, prescaler wraps normally, expired never asserts.
  - If the reload register is 0, behave as undefined (normal expiry to DONE).
- Undefined: no reload register; expiry enters DONE as above.

Test Plan (TICK_DIV=4):
- Reset: rst_n low mid-RUN with load_val 0x00_0105 loaded -> all outputs 0 asynchronously, state IDLE; start ignored since time_q==0.
- Basic countdown: load 0x00_0003, start -> time_q 0x000002/0x000001/0x000000 at 4/8/12 cycles after start; done one cycle at 12 cycles; expired stays 1; running 0.
- Borrow chain: load 0x10_0000, start -> after 4 cycles time_q=0x09_5999.
- Pause/resume: load 0x00_0010, start, stop after 6 cycles -> time_q 0x000009 held 20 cycles; start -> next decrement 2 cycles later (prescaler retained).
- Priority and sanitising: load 0xFF_FFFF -> time_q 0x59_5999. start+stop in the same cycle from PAUSE -> stays PAUSE. load during RUN -> IDLE with new value.
- Auto-reload (macro defined): load 0x00_0002, start -> done pulses every 8 cycles; time_q sequence 1,0->2,1,...; expired never 1.
